receptor_teclado: RTL and testbench
===================================

Name: receptor_teclado

Overview:
- Downstream consumer of the keypad model `teclado`, which drives the `teclas[4:0]` and `valido` pair.
- Synchronises the asynchronous key bus into the system clock and qualifies each press by a minimum stable time.
- Captures exactly one 5-bit code per press into a small FIFO.
- Presents captured codes to the rest of the design on a valid/ready interface, with sticky overflow reporting.

Parameters:
- ANCHO, 5, key code width in bits.
- MIN_ESTABLE, 4, consecutive synchronised samples (valido=1, same code) needed to accept a press; legal range 1..63.
- PROFUNDIDAD, 4, FIFO depth in entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- teclas  input  ANCHO  raw key code from the keypad; may be X while valido=0.
- valido  input  1  raw key-pressed flag from the keypad, asynchronous.
- dato  output  ANCHO  FIFO head code; 0 when empty.
- dato_valido  output  1  FIFO not empty.
- listo  input  1  consumer ready; pop occurs when dato_valido && listo.
- ocupacion  output  clog2(PROFUNDIDAD)+1  current FIFO entry count.
- desborde  output  1  sticky: a qualified press was dropped because the FIFO was full.

Behaviour:
- Reset (async, reset_L=0): dato=0, dato_valido=0, ocupacion=0, desborde=0. Synchroniser flops, counter and FIFO pointers clear; FSM goes to ESPERA. Reset asserted mid-press discards the press.
- Synchroniser: two flops on valido and on teclas (valido_s, teclas_s).
  - When valido_s=0, teclas_s is don't-care and must never reach state or FIFO; X must not propagate.
- FSM, evaluated on the synchronised signals:
  - ESPERA: if valido_s=1, latch teclas_s into cod, set cnt=1, go to CONTANDO. If MIN_ESTABLE=1, write immediately and go to CAPTURADA instead.
  - CONTANDO, valido_s=0: discard the press (glitch), go to ESPERA.
  - CONTANDO, teclas_s != cod: relatch cod, set cnt=1.
  - CONTANDO, code unchanged and cnt+1 == MIN_ESTABLE: issue FIFO write of cod, go to CAPTURADA.
  - CONTANDO, otherwise: cnt++.
  - CAPTURADA: ignore all code changes; go to ESPERA only when valido_s=0. This guarantees one capture per press.
- Latency: inputs stable before edge 0 give a FIFO write at edge 1+MIN_ESTABLE. With an empty FIFO, dato_valido=1 and dato=code after that edge (5 edges for the default).
- cnt is 6 bits and saturates; no wrap-around is possible within the legal range.
- FIFO (first-word fall-through): dato shows the head combinationally from registered storage.
  - Pop on dato_valido && listo. Pop on empty is ignored; listo alone has no effect.
  - Write is accepted if ocupacion < PROFUNDIDAD, or if a pop occurs in the same cycle.
  - Write with full FIFO and no pop: entry dropped, desborde=1 from the next edge until reset.
  - Simultaneous push+pop: ocupacion unchanged, order preserved.
  - Pointers wrap modulo PROFUNDIDAD.

Decomposition:
- Shared header receptor_teclado_defs.vh holds:
  - FSM state encodings ESPERA=2'd0, CONTANDO=2'd1, CAPTURADA=2'd2;
  - default widths;
  - the clog2 helper function.
- One natural sub-module: fifo_teclas (parameterised FWFT FIFO with push/pop/full/empty/ocupacion). The FSM and synchroniser stay in receptor_teclado.

Test Plan:
- Single press: teclas=5'b10110, valido=1 held 10 cycles, listo=1 -> exactly one dato=5'b10110 with dato_valido high 1 cycle, 5 edges after valido applied; ocupacion returns to 0.
- Glitch: valido=1 for 3 cycles, then 0 -> no write; dato_valido stays 0; FSM back in ESPERA.
- Code change mid-count: 5'h03 for 2 cycles, then 5'h07 for 6 cycles -> only 5'h07 captured.
- X tolerance: teclas=5'bx with valido=0 for 11 cycles between presses -> no X on dato, dato_valido or ocupacion.
- Overflow: listo=0, 5 qualified presses 5'h01..5'h05 -> ocupacion=4, desborde=1 after the 5th; then listo=1 drains 01,02,03,04 in order; desborde stays 1.
- Full with simultaneous pop: FIFO full, listo=1 on the edge of a new write 5'h1F -> write accepted, ocupacion stays 4, desborde stays 0. Async reset mid-CONTANDO -> all outputs 0 immediately.

Source files
------------

// File: rtl/receptor_teclado_pkg.sv
// receptor_teclado_pkg
//   Shared definitions for the keypad receiver: default widths, FSM state
//   encoding and a constant clog2 helper used to size counters and pointers.
package receptor_teclado_pkg;

  localparam int ANCHO_DEF       = 5;
  localparam int MIN_ESTABLE_DEF = 4;
  localparam int PROFUNDIDAD_DEF = 4;

  // Stability counter width; covers the full 1..63 range of MIN_ESTABLE.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    CONTANDO  = 2'd1,
    CAPTURADA = 2'd2
  } estado_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/receptor_teclado_fifo_teclas.sv
// fifo_teclas
//   First-word-fall-through FIFO for captured key codes. The head entry is
//   visible on o_dato whenever the FIFO holds data (0 otherwise).
//   Ports:
//     clk, reset_L   system clock, async active-low reset
//     i_push, i_dato write request and code
//     i_pop          consumer ready; pops only when not empty
//     o_dato         head code (0 when empty)
//     o_valido       FIFO not empty
//     o_ocupacion    entry count
//     o_desborde     sticky: a write was dropped because the FIFO was full
module fifo_teclas
  import receptor_teclado_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic                          i_push,
  input  logic [ANCHO-1:0]              i_dato,
  input  logic                          i_pop,
  output logic [ANCHO-1:0]              o_dato,
  output logic                          o_valido,
  output logic [clog2(PROFUNDIDAD):0]   o_ocupacion,
  output logic                          o_desborde
);

  localparam int PW = clog2(PROFUNDIDAD);
  localparam logic [PW:0] LLENO = (PW+1)'(PROFUNDIDAD);

  logic [ANCHO-1:0] r_mem [PROFUNDIDAD];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [PW:0]      r_ocup;
  logic             r_desborde;

  logic w_vacio;
  logic w_lleno;
  logic w_pop;
  logic w_push;

  assign w_vacio = (r_ocup == '0);
  assign w_lleno = (r_ocup == LLENO);
  assign w_pop   = i_pop && !w_vacio;
  // When full, a same-cycle pop frees the slot being written (r_wr == r_rd).
  assign w_push  = i_push && (!w_lleno || w_pop);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_ocup     <= '0;
      r_desborde <= 1'b0;
    end else begin
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push) r_wr <= r_wr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_ocup <= r_ocup + (PW+1)'(1);
        2'b01:   r_ocup <= r_ocup - (PW+1)'(1);
        default: r_ocup <= r_ocup;
      endcase
      if (i_push && !w_push) r_desborde <= 1'b1;
    end
  end

  // Storage needs no reset; the output is gated while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_dato;
  end

  assign o_dato      = w_vacio ? '0 : r_mem[r_rd];
  assign o_valido    = !w_vacio;
  assign o_ocupacion = r_ocup;
  assign o_desborde  = r_desborde;

endmodule

// File: rtl/receptor_teclado.sv
// receptor_teclado
//   Receives the asynchronous keypad bus (teclas/valido), synchronises it,
//   accepts a press once the same code has been seen on MIN_ESTABLE
//   consecutive synchronised samples, and queues exactly one code per press.
//
//   state     | meaning
//   ESPERA    | no key held; waiting for valido_s
//   CONTANDO  | key held; counting consecutive samples of the same code
//   CAPTURADA | press already queued; waiting for release
//
//   Ports:
//     clk, reset_L   system clock, async active-low reset
//     teclas, valido raw keypad bus (teclas is don't-care while valido=0)
//     dato           FIFO head code (0 when empty)
//     dato_valido    FIFO not empty
//     listo          consumer ready; pop on dato_valido && listo
//     ocupacion      FIFO entry count
//     desborde       sticky overflow flag
module receptor_teclado
  import receptor_teclado_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int MIN_ESTABLE = MIN_ESTABLE_DEF,
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [ANCHO-1:0]             teclas,
  input  logic                         valido,
  output logic [ANCHO-1:0]             dato,
  output logic                         dato_valido,
  input  logic                         listo,
  output logic [clog2(PROFUNDIDAD):0]  ocupacion,
  output logic                         desborde
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_ESTABLE);

  logic             r_valido_m;
  logic             r_valido_s;
  logic [ANCHO-1:0] r_teclas_m;
  logic [ANCHO-1:0] r_teclas_s;

  estado_t          r_estado;
  logic [ANCHO-1:0] r_cod;
  logic [CNT_W-1:0] r_cnt;

  logic             w_mismo;
  logic [CNT_W-1:0] w_cnt_sig;
  logic             w_push;
  logic [ANCHO-1:0] w_dato_push;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valido_m <= 1'b0;
      r_valido_s <= 1'b0;
      r_teclas_m <= '0;
      r_teclas_s <= '0;
    end else begin
      r_valido_m <= valido;
      r_valido_s <= r_valido_m;
      r_teclas_m <= teclas;
      r_teclas_s <= r_teclas_m;
    end
  end

  assign w_mismo   = (r_teclas_s == r_cod);
  assign w_cnt_sig = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // Write strobe decoded from the current state and synchronised inputs.
  // valido_s is tested first so a don't-care code never qualifies a write.
  always_comb begin
    w_push      = 1'b0;
    w_dato_push = r_cod;
    case (r_estado)
      ESPERA: begin
        w_push      = r_valido_s && (MIN_ESTABLE == 1);
        w_dato_push = r_teclas_s;
      end
      CONTANDO: begin
        if (r_valido_s && w_mismo && (w_cnt_sig == MIN_CNT)) w_push = 1'b1;
      end
      default: w_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_estado <= ESPERA;
      r_cod    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_estado)
        ESPERA: begin
          if (r_valido_s) begin
            r_cod    <= r_teclas_s;
            r_cnt    <= CNT_W'(1);
            r_estado <= (MIN_ESTABLE == 1) ? CAPTURADA : CONTANDO;
          end
        end
        CONTANDO: begin
          if (!r_valido_s) begin
            r_cnt    <= '0;
            r_estado <= ESPERA;
          end else if (!w_mismo) begin
            r_cod <= r_teclas_s;
            r_cnt <= CNT_W'(1);
          end else if (w_cnt_sig == MIN_CNT) begin
            r_estado <= CAPTURADA;
          end else begin
            r_cnt <= w_cnt_sig;
          end
        end
        CAPTURADA: begin
          if (!r_valido_s) begin
            r_cnt    <= '0;
            r_estado <= ESPERA;
          end
        end
        default: r_estado <= ESPERA;
      endcase
    end
  end

  fifo_teclas #(
    .ANCHO       (ANCHO),
    .PROFUNDIDAD (PROFUNDIDAD)
  ) u_fifo (
    .clk         (clk),
    .reset_L     (reset_L),
    .i_push      (w_push),
    .i_dato      (w_dato_push),
    .i_pop       (listo),
    .o_dato      (dato),
    .o_valido    (dato_valido),
    .o_ocupacion (ocupacion),
    .o_desborde  (desborde)
  );

endmodule

// File: tb/tb_receptor_teclado.sv
module tb_receptor_teclado;

  localparam int ANCHO = 5;
  localparam int MIN   = 4;
  localparam int PROF  = 4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [4:0] teclas;
  logic       valido;
  logic       listo;
  logic [4:0] dato;
  logic       dato_valido;
  logic [2:0] ocupacion;
  logic       desborde;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  receptor_teclado #(
    .ANCHO       (ANCHO),
    .MIN_ESTABLE (MIN),
    .PROFUNDIDAD (PROF)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .teclas      (teclas),
    .valido      (valido),
    .dato        (dato),
    .dato_valido (dato_valido),
    .listo       (listo),
    .ocupacion   (ocupacion),
    .desborde    (desborde)
  );

  typedef struct {
    logic       v;
    logic [4:0] t;
    logic       l;
    logic       e_dv;
    logic [4:0] e_dato;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tabla[$];

  // reference model state (behavioural: sample history, run length, queue)
  logic       m_v1, m_v2;
  logic [4:0] m_t1, m_t2;
  int         m_run;
  logic [4:0] m_code;
  bit         m_capt;
  logic [4:0] m_q[$];
  bit         m_desb;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
    end
  endtask

  task automatic pulsa(input logic [4:0] c);
    valido = 1'b1;
    teclas = c;
    repeat (8) step();
    valido = 1'b0;
    teclas = 5'bx;
    repeat (4) step();
  endtask

  task automatic pulso_reset();
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
  endtask

  task automatic modelo_reset();
    m_v1 = 0; m_v2 = 0; m_t1 = '0; m_t2 = '0;
    m_run = 0; m_code = '0; m_capt = 0; m_desb = 0;
    m_q.delete();
  endtask

  // One clock edge of the receiver described at press level: the sample
  // seen at this edge is two edges old; a press is queued once its code has
  // been seen MIN times in a row, at most once until the key is released.
  task automatic modelo_flanco();
    bit push, pop;
    push = 0;
    if (!m_v2) begin
      m_run  = 0;
      m_capt = 0;
    end else begin
      if (m_run > 0 && m_t2 == m_code) m_run = (m_run < 63) ? m_run + 1 : 63;
      else begin
        m_run  = 1;
        m_code = m_t2;
      end
      if (m_run == MIN && !m_capt) begin
        push   = 1;
        m_capt = 1;
      end
    end
    pop = (m_q.size() > 0) && listo;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < PROF) m_q.push_back(m_code);
      else m_desb = 1;
    end
    m_v2 = m_v1; m_t2 = m_t1;
    m_v1 = valido; m_t1 = teclas;
  endtask

  initial begin
    int n;
    logic mv;
    logic [4:0] code;
    int seg;

    // stimulus table: single press, glitch, code change mid-count (listo=1)
    for (int i = 0; i < 14; i++)
      tabla.push_back('{v: (i < 10), t: (i < 10) ? 5'h16 : 5'bx, l: 1'b1,
                        e_dv: (i == 5), e_dato: (i == 5) ? 5'h16 : 5'h00,
                        e_occ: (i == 5) ? 3'd1 : 3'd0});
    for (int i = 0; i < 9; i++)
      tabla.push_back('{v: (i < 3), t: (i < 3) ? 5'h0A : 5'bx, l: 1'b1,
                        e_dv: 1'b0, e_dato: 5'h00, e_occ: 3'd0});
    for (int i = 0; i < 12; i++)
      tabla.push_back('{v: (i < 8), t: (i < 2) ? 5'h03 : ((i < 8) ? 5'h07 : 5'bx),
                        l: 1'b1, e_dv: (i == 7), e_dato: (i == 7) ? 5'h07 : 5'h00,
                        e_occ: (i == 7) ? 3'd1 : 3'd0});

    reset_L = 1'b0;
    valido  = 1'b0;
    teclas  = 5'h00;
    listo   = 1'b0;
    #1;
    chk("reset_dato", dato, 0);
    chk("reset_dato_valido", dato_valido, 0);
    chk("reset_ocupacion", ocupacion, 0);
    chk("reset_desborde", desborde, 0);
    repeat (2) step();
    reset_L = 1'b1;

    foreach (tabla[i]) begin
      valido = tabla[i].v;
      teclas = tabla[i].t;
      listo  = tabla[i].l;
      step();
      chk($sformatf("tabla%0d_dato_valido", i), dato_valido, tabla[i].e_dv);
      chk($sformatf("tabla%0d_dato", i), dato, tabla[i].e_dato);
      chk($sformatf("tabla%0d_ocupacion", i), ocupacion, tabla[i].e_occ);
    end

    // X on the code bus while released must never reach the outputs
    valido = 1'b0;
    teclas = 5'bx;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("x_salidas_conocidas", int'($isunknown({dato, dato_valido, ocupacion})), 0);
      chk("x_sin_escritura", dato_valido, 0);
    end
    valido = 1'b1;
    teclas = 5'h19;
    n = 0;
    while (!dato_valido && n < 12) begin
      step();
      n++;
    end
    chk("x_captura_latencia", n, 6);
    chk("x_captura_dato", dato, 5'h19);
    step();
    valido = 1'b0;
    teclas = 5'bx;
    repeat (4) step();

    // overflow: five presses with no consumer
    listo = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pulsa(5'(k));
      if (k == 4) begin
        chk("lleno_ocupacion", ocupacion, 4);
        chk("lleno_sin_desborde", desborde, 0);
      end
    end
    chk("desborde_ocupacion", ocupacion, 4);
    chk("desborde_flag", desborde, 1);
    listo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drenaje%0d_dato", k), dato, k);
      chk($sformatf("drenaje%0d_valido", k), dato_valido, 1);
      step();
    end
    chk("drenaje_vacio", dato_valido, 0);
    chk("drenaje_ocupacion", ocupacion, 0);
    chk("desborde_pegajoso", desborde, 1);

    // full FIFO with pop on the same edge as a new write
    pulso_reset();
    chk("reset_limpia_desborde", desborde, 0);
    listo = 1'b0;
    for (int k = 0; k < 4; k++) pulsa(5'h11 + 5'(k));
    chk("lleno2_ocupacion", ocupacion, 4);
    valido = 1'b1;
    teclas = 5'h1F;
    repeat (5) step();
    chk("pre_push_ocupacion", ocupacion, 4);
    listo = 1'b1;
    step();
    listo = 1'b0;
    chk("pushpop_ocupacion", ocupacion, 4);
    chk("pushpop_desborde", desborde, 0);
    chk("pushpop_cabeza", dato, 5'h12);
    valido = 1'b0;
    teclas = 5'bx;
    repeat (4) step();
    listo = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("orden%0d_dato", k), dato, (k < 3) ? 5'h12 + k : 5'h1F);
      step();
    end
    chk("orden_vacio", dato_valido, 0);

    // async reset in the middle of a count
    listo = 1'b0;
    pulsa(5'h05);
    chk("pre_reset_valido", dato_valido, 1);
    valido = 1'b1;
    teclas = 5'h0C;
    repeat (3) step();
    reset_L = 1'b0;
    #1;
    chk("reset_async_dato", dato, 0);
    chk("reset_async_valido", dato_valido, 0);
    chk("reset_async_ocupacion", ocupacion, 0);
    chk("reset_async_desborde", desborde, 0);
    valido = 1'b0;
    teclas = 5'bx;
    step();
    reset_L = 1'b1;
    repeat (8) step();
    chk("reset_descarta_pulsacion", dato_valido, 0);

    // randomized traffic against the reference model
    pulso_reset();
    modelo_reset();
    seg  = 0;
    mv   = 1'b0;
    code = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulso_reset();
        modelo_reset();
      end
      if (seg == 0) begin
        mv   = 1'($urandom_range(0, 1));
        seg  = $urandom_range(1, 10);
        code = 5'($urandom);
      end
      seg--;
      if (mv && $urandom_range(0, 11) == 0) code = 5'($urandom);
      valido = mv;
      teclas = mv ? code : 5'($urandom);
      listo  = ($urandom_range(0, 9) < 3);
      modelo_flanco();
      step();
      chk("rnd_dato_valido", dato_valido, (m_q.size() > 0));
      chk("rnd_dato", dato, (m_q.size() > 0) ? m_q[0] : 5'h00);
      chk("rnd_ocupacion", ocupacion, m_q.size());
      chk("rnd_desborde", desborde, m_desb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
